// File: rtl/soc_sram_responder.sv
// Word-organised SRAM responder for the CPU fetch and data ports,
// with a small MMIO window holding a timer and LED/NUM registers.
module soc_sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = 32'h1faf_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num
);

  localparam logic [15:0] OFF_TIMER = 16'he000;
  localparam logic [15:0] OFF_LED   = 16'hf000;
  localparam logic [15:0] OFF_NUM   = 16'hf010;

  logic [31:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] i_idx;
  logic [ADDR_W-1:0] d_idx;
  logic [15:0]       d_off;
  logic              d_mmio;
  logic              d_wr;
  logic              d_rd;
  logic              ram_we;

  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic [31:0] timer_q, timer_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] mmio_rdata;
  logic [31:0] led_w;

  logic unused_bits;
  assign unused_bits = ^{inst_sram_wen, inst_sram_wdata,
                         inst_sram_addr[31:ADDR_W+2],
                         inst_sram_addr[1:0]};

  assign i_idx  = inst_sram_addr[ADDR_W+1:2];
  assign d_idx  = data_sram_addr[ADDR_W+1:2];
  assign d_off  = data_sram_addr[15:0];
  assign d_mmio = data_sram_addr[31:16] == MMIO_BASE[31:16];
  assign d_wr   = data_sram_en && (data_sram_wen != 4'h0);
  assign d_rd   = data_sram_en && (data_sram_wen == 4'h0);
  assign ram_we = d_wr && !d_mmio && !reset;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    mmio_rdata = 32'h0;
    case (d_off)
      OFF_TIMER: mmio_rdata = timer_q;
      OFF_LED:   mmio_rdata = {16'h0, led_q};
      OFF_NUM:   mmio_rdata = num_q;
      default:   mmio_rdata = 32'h0;
    endcase
  end

  always_comb begin
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    timer_d      = timer_q + 32'd1;
    led_d        = led_q;
    num_d        = num_q;
    led_w        = merge({16'h0, led_q}, data_sram_wdata, data_sram_wen);
    if (inst_sram_en)
      inst_rdata_d = mem[i_idx];
    if (d_rd)
      data_rdata_d = d_mmio ? mmio_rdata : mem[d_idx];
    // A timer write wins per lane over the increment
    if (d_wr && d_mmio) begin
      case (d_off)
        OFF_TIMER: timer_d = merge(timer_q + 32'd1,
                                   data_sram_wdata,
                                   data_sram_wen);
        OFF_LED:   led_d   = led_w[15:0];
        OFF_NUM:   num_d   = merge(num_q,
                                   data_sram_wdata,
                                   data_sram_wen);
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rdata_q <= 32'h0;
      data_rdata_q <= 32'h0;
      timer_q      <= 32'h0;
      led_q        <= 16'h0;
      num_q        <= 32'h0;
    end else begin
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      timer_q      <= timer_d;
      led_q        <= led_d;
      num_q        <= num_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++)
        if (data_sram_wen[i])
          mem[d_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
    end
  end

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;
  assign led             = led_q;
  assign num             = num_q;

endmodule

// File: tb/tb_soc_sram_responder.sv
// Directed bench for soc_sram_responder: reset, byte lanes, collision,
// hold/aliasing, MMIO registers and timer behaviour.
module tb_soc_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [15:0] led;
  logic [31:0] num;

  int vecs = 0;
  int errs = 0;

  localparam logic [31:0] A_TIMER = 32'h1faf_e000;
  localparam logic [31:0] A_LED   = 32'h1faf_f000;
  localparam logic [31:0] A_NUM   = 32'h1faf_f010;

  soc_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .led             (led),
    .num             (num)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic dwrite(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0]  w);
    data_sram_en    = 1'b1;
    data_sram_wen   = w;
    data_sram_addr  = a;
    data_sram_wdata = d;
    tick();
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
  endtask

  task automatic dread(input logic [31:0] a);
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'h0;
    data_sram_addr = a;
    tick();
    data_sram_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a);
    inst_sram_en   = 1'b1;
    inst_sram_addr = a;
    tick();
    inst_sram_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dwrite(32'h0, 32'h5a5a_1234, 4'hf);
    dwrite(A_LED, 32'h0000_ffff, 4'hf);
    dwrite(A_NUM, 32'h7777_7777, 4'hf);
    fetch(32'h0);
    dread(32'h0);
    reset           = 1'b1;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hf;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'hdead_beef;
    inst_sram_en    = 1'b1;
    inst_sram_addr  = 32'h0;
    tick();
    tick();
    reset         = 1'b0;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
    inst_sram_en  = 1'b0;
    vecs++;
    if (inst_sram_rdata !== 32'h0) begin
      errs++;
      $display("FAIL rst_inst got %h exp %h", inst_sram_rdata, 32'h0);
    end
    vecs++;
    if (data_sram_rdata !== 32'h0) begin
      errs++;
      $display("FAIL rst_data got %h exp %h", data_sram_rdata, 32'h0);
    end
    vecs++;
    if (led !== 16'h0) begin
      errs++;
      $display("FAIL rst_led got %h exp %h", led, 16'h0);
    end
    vecs++;
    if (num !== 32'h0) begin
      errs++;
      $display("FAIL rst_num got %h exp %h", num, 32'h0);
    end
    dread(A_TIMER);
    vecs++;
    if (data_sram_rdata !== 32'h0) begin
      errs++;
      $display("FAIL rst_timer got %h exp %h", data_sram_rdata, 32'h0);
    end
    dread(32'h0);
    vecs++;
    if (data_sram_rdata !== 32'h5a5a_1234) begin
      errs++;
      $display("FAIL rst_nowrite got %h exp %h",
               data_sram_rdata, 32'h5a5a_1234);
    end
  endtask

  task automatic test_byte_lanes;
    dwrite(32'h100, 32'h1122_3344, 4'hf);
    dwrite(32'h100, 32'haabb_ccdd, 4'b0101);
    dread(32'h100);
    vecs++;
    if (data_sram_rdata !== 32'h11bb_33dd) begin
      errs++;
      $display("FAIL byte_lanes got %h exp %h",
               data_sram_rdata, 32'h11bb_33dd);
    end
    dwrite(32'h103, 32'h5566_7788, 4'b1000);
    dread(32'h101);
    vecs++;
    if (data_sram_rdata !== 32'h55bb_33dd) begin
      errs++;
      $display("FAIL lane3_lowbits got %h exp %h",
               data_sram_rdata, 32'h55bb_33dd);
    end
  endtask

  task automatic test_collision;
    dwrite(32'h40, 32'h0, 4'hf);
    inst_sram_en    = 1'b1;
    inst_sram_addr  = 32'h40;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hf;
    data_sram_addr  = 32'h40;
    data_sram_wdata = 32'hcafe_f00d;
    tick();
    inst_sram_en  = 1'b0;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
    vecs++;
    if (inst_sram_rdata !== 32'h0) begin
      errs++;
      $display("FAIL collide_old got %h exp %h", inst_sram_rdata, 32'h0);
    end
    fetch(32'h40);
    vecs++;
    if (inst_sram_rdata !== 32'hcafe_f00d) begin
      errs++;
      $display("FAIL collide_new got %h exp %h",
               inst_sram_rdata, 32'hcafe_f00d);
    end
  endtask

  task automatic test_hold_alias;
    dwrite(32'h8, 32'h1357_2468, 4'hf);
    dwrite(32'hc, 32'h9999_0000, 4'hf);
    fetch(32'h8);
    inst_sram_addr = 32'hc;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (inst_sram_rdata !== 32'h1357_2468) begin
        errs++;
        $display("FAIL inst_hold%0d got %h exp %h",
                 i, inst_sram_rdata, 32'h1357_2468);
      end
    end
    dread(32'h4008);
    vecs++;
    if (data_sram_rdata !== 32'h1357_2468) begin
      errs++;
      $display("FAIL alias got %h exp %h",
               data_sram_rdata, 32'h1357_2468);
    end
    dwrite(32'h200, 32'h0f0f_0f0f, 4'hf);
    vecs++;
    if (data_sram_rdata !== 32'h1357_2468) begin
      errs++;
      $display("FAIL data_hold_wr got %h exp %h",
               data_sram_rdata, 32'h1357_2468);
    end
  endtask

  task automatic test_mmio;
    dwrite(A_LED, 32'h0000_1234, 4'hf);
    vecs++;
    if (led !== 16'h1234) begin
      errs++;
      $display("FAIL led got %h exp %h", led, 16'h1234);
    end
    dwrite(A_NUM, 32'h1234_5678, 4'b0011);
    vecs++;
    if (num !== 32'h0000_5678) begin
      errs++;
      $display("FAIL num got %h exp %h", num, 32'h0000_5678);
    end
    dread(A_LED);
    vecs++;
    if (data_sram_rdata !== 32'h0000_1234) begin
      errs++;
      $display("FAIL led_rd got %h exp %h",
               data_sram_rdata, 32'h0000_1234);
    end
    dwrite(32'h1faf_8000, 32'hffff_ffff, 4'hf);
    dread(32'h1faf_8000);
    vecs++;
    if (data_sram_rdata !== 32'h0) begin
      errs++;
      $display("FAIL mmio_hole got %h exp %h", data_sram_rdata, 32'h0);
    end
    dwrite(32'h3000, 32'h0bad_c0de, 4'hf);
    fetch(A_LED);
    vecs++;
    if (inst_sram_rdata !== 32'h0bad_c0de) begin
      errs++;
      $display("FAIL inst_no_mmio got %h exp %h",
               inst_sram_rdata, 32'h0bad_c0de);
    end
  endtask

  task automatic test_timer;
    dwrite(A_TIMER, 32'hffff_fffe, 4'hf);
    tick();
    dread(A_TIMER);
    vecs++;
    if (data_sram_rdata !== 32'hffff_ffff) begin
      errs++;
      $display("FAIL timer_pre got %h exp %h",
               data_sram_rdata, 32'hffff_ffff);
    end
    tick();
    dread(A_TIMER);
    vecs++;
    if (data_sram_rdata !== 32'h0000_0001) begin
      errs++;
      $display("FAIL timer_wrap got %h exp %h",
               data_sram_rdata, 32'h0000_0001);
    end
    dwrite(A_TIMER, 32'h0000_01ff, 4'hf);
    dwrite(A_TIMER, 32'h0, 4'b0001);
    dread(A_TIMER);
    vecs++;
    if (data_sram_rdata !== 32'h0000_0200) begin
      errs++;
      $display("FAIL timer_lane got %h exp %h",
               data_sram_rdata, 32'h0000_0200);
    end
  endtask

  initial begin
    reset           = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_wen   = 4'h0;
    inst_sram_addr  = 32'h0;
    inst_sram_wdata = 32'h0;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    #1;
    test_reset();
    test_byte_lanes();
    test_collision();
    test_hold_alias();
    test_mmio();
    test_timer();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
